rtc_bus_sequencer: RTL and testbench

//  Sits directly upstream of the RTC bus-timing FSM (multiplexed A/D bus, CS/WR/RD).
//  - Accepts one burst command (read-all or write-all) and splits it into NREG single-register

---
 rtl/rtc_bus_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_sequencer.sv
// Burst sequencer for the RTC bus-timing FSM: expands one read-all/write-all
// command into NREG single-register transactions and steers the shared A/D bus.
module rtc_bus_sequencer #(
  parameter int unsigned NREG      = 9,
  parameter logic [7:0]  BASE_ADDR = 8'h21,
  parameter int unsigned TIMEOUT   = 63
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       cmd_valid_i,
  input  logic       cmd_write_i,
  output logic       cmd_ready_o,
  output logic [7:0] wr_idx_o,
  input  logic [7:0] wr_data_i,
  output logic       rd_valid_o,
  output logic [7:0] rd_idx_o,
  output logic [7:0] rd_data_o,
  output logic       done_o,
  output logic       err_o,
  output logic       fsm_start_o,
  output logic       fsm_write_o,
  output logic       fsm_rst_o,
  input  logic       fsm_capture_i,
  input  logic       fsm_dir_phase_i,
  input  logic       fsm_rd_n_i,
  input  logic       fsm_done_i,
  input  logic [7:0] bus_in_i,
  output logic [7:0] bus_out_o,
  output logic       bus_oe_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_DONE,
    S_NEXT,
    S_FINISH,
    S_ABORT
  } state_e;

  localparam logic [7:0] LAST_IDX  = 8'(NREG - 1);
  localparam logic [5:0] TMO_LIMIT = 6'(TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic       wr_mode_q, wr_mode_d;
  logic [5:0] tmo_q, tmo_d;
  logic [7:0] rd_data_q, rd_data_d;

  logic       tmo_hit;
  logic       last_idx;
  logic       rst_pulse;
  logic       bus_active;
  logic [7:0] addr;

  // The counter is compared after this cycle's increment, so the abort
  // decision is taken in the TIMEOUT-th WAIT_DONE cycle.
  assign tmo_hit  = (tmo_q + 6'd1) == TMO_LIMIT;
  assign last_idx = (idx_q == LAST_IDX);
  assign addr     = BASE_ADDR + idx_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (fsm_done_i) begin
          state_d = S_NEXT;
        end else if (tmo_hit) begin
          state_d = S_ABORT;
        end
      end
      S_NEXT:   state_d = last_idx ? S_FINISH : S_LAUNCH;
      S_FINISH: state_d = S_IDLE;
      S_ABORT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = 1'b0;
    fsm_start_o = 1'b0;
    rd_valid_o  = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    rst_pulse   = 1'b0;
    bus_active  = 1'b0;
    case (state_q)
      S_IDLE: cmd_ready_o = 1'b1;
      S_LAUNCH: begin
        fsm_start_o = 1'b1;
        bus_active  = 1'b1;
      end
      S_WAIT_DONE: bus_active = 1'b1;
      S_NEXT: begin
        rst_pulse  = 1'b1;
        rd_valid_o = ~wr_mode_q;
      end
      S_FINISH: done_o = 1'b1;
      S_ABORT: begin
        err_o     = 1'b1;
        rst_pulse = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    idx_d     = idx_q;
    wr_mode_d = wr_mode_q;
    tmo_d     = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          wr_mode_d = cmd_write_i;
          idx_d     = 8'h00;
        end
      end
      S_LAUNCH:    tmo_d = 6'd0;
      S_WAIT_DONE: tmo_d = tmo_q + 6'd1;
      S_NEXT: begin
        if (!last_idx) begin
          idx_d = idx_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Keeps updating while RD is low so the final sample before RD rises wins.
  always_comb begin
    rd_data_d = rd_data_q;
    if (fsm_dir_phase_i && !fsm_rd_n_i && !wr_mode_q) begin
      rd_data_d = bus_in_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idx_q     <= 8'h00;
      wr_mode_q <= 1'b0;
      tmo_q     <= 6'd0;
      rd_data_q <= 8'h00;
    end else begin
      idx_q     <= idx_d;
      wr_mode_q <= wr_mode_d;
      tmo_q     <= tmo_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    bus_oe_o  = 1'b0;
    bus_out_o = 8'h00;
    if (bus_active) begin
      if (fsm_capture_i && !fsm_dir_phase_i) begin
        bus_oe_o  = 1'b1;
        bus_out_o = addr;
      end else if (fsm_dir_phase_i && wr_mode_q) begin
        bus_oe_o  = 1'b1;
        bus_out_o = wr_data_i;
      end
    end
  end

  // The bus FSM is held in reset together with this block.
  assign fsm_rst_o   = reset_i | rst_pulse;
  assign fsm_write_o = wr_mode_q & (state_q != S_IDLE);
  assign wr_idx_o    = idx_q;
  assign rd_idx_o    = rd_valid_o ? idx_q : 8'h00;
  assign rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: two instances (default and BASE_ADDR=FE/NREG=3)
// driven by a scripted bus-FSM responder and checked against a burst-level model.
module tb_rtc_bus_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       cmd_valid [2];
  logic       cmd_write [2];
  logic       cmd_ready [2];
  logic [7:0] wr_idx [2];
  logic [7:0] wr_data [2];
  logic       rd_valid [2];
  logic [7:0] rd_idx [2];
  logic [7:0] rd_data [2];
  logic       done [2];
  logic       err [2];
  logic       fsm_start [2];
  logic       fsm_write [2];
  logic       fsm_rst [2];
  logic       fsm_capture [2];
  logic       fsm_dir_phase [2];
  logic       fsm_rd_n [2];
  logic       fsm_done [2];
  logic [7:0] bus_in [2];
  logic [7:0] bus_out [2];
  logic       bus_oe [2];

  // Upstream write-data lookup: each register is written with its inverted index.
  assign wr_data[0] = ~wr_idx[0];
  assign wr_data[1] = ~wr_idx[1];

  rtc_bus_sequencer #(.NREG(9), .BASE_ADDR(8'h21), .TIMEOUT(63)) u_dut0 (
    .clk_i(clk), .reset_i(reset),
    .cmd_valid_i(cmd_valid[0]), .cmd_write_i(cmd_write[0]), .cmd_ready_o(cmd_ready[0]),
    .wr_idx_o(wr_idx[0]), .wr_data_i(wr_data[0]),
    .rd_valid_o(rd_valid[0]), .rd_idx_o(rd_idx[0]), .rd_data_o(rd_data[0]),
    .done_o(done[0]), .err_o(err[0]),
    .fsm_start_o(fsm_start[0]), .fsm_write_o(fsm_write[0]), .fsm_rst_o(fsm_rst[0]),
    .fsm_capture_i(fsm_capture[0]), .fsm_dir_phase_i(fsm_dir_phase[0]),
    .fsm_rd_n_i(fsm_rd_n[0]), .fsm_done_i(fsm_done[0]),
    .bus_in_i(bus_in[0]), .bus_out_o(bus_out[0]), .bus_oe_o(bus_oe[0])
  );

  rtc_bus_sequencer #(.NREG(3), .BASE_ADDR(8'hFE), .TIMEOUT(63)) u_dut1 (
    .clk_i(clk), .reset_i(reset),
    .cmd_valid_i(cmd_valid[1]), .cmd_write_i(cmd_write[1]), .cmd_ready_o(cmd_ready[1]),
    .wr_idx_o(wr_idx[1]), .wr_data_i(wr_data[1]),
    .rd_valid_o(rd_valid[1]), .rd_idx_o(rd_idx[1]), .rd_data_o(rd_data[1]),
    .done_o(done[1]), .err_o(err[1]),
    .fsm_start_o(fsm_start[1]), .fsm_write_o(fsm_write[1]), .fsm_rst_o(fsm_rst[1]),
    .fsm_capture_i(fsm_capture[1]), .fsm_dir_phase_i(fsm_dir_phase[1]),
    .fsm_rd_n_i(fsm_rd_n[1]), .fsm_done_i(fsm_done[1]),
    .bus_in_i(bus_in[1]), .bus_out_o(bus_out[1]), .bus_oe_o(bus_oe[1])
  );

  int checks = 0;
  int errors = 0;

  // Model: which register each instance is working on, whether a transaction
  // is in progress, burst direction, and the reads still owed to the host.
  logic        m_active [2];
  logic        m_mode [2];
  logic [7:0]  m_idx [2];
  logic [15:0] exp_rd [$];
  int          n_done [2];
  int          n_err [2];
  int          n_rdv [2];
  logic [7:0]  obs_addr [256];
  logic [7:0]  obs_wd [256];
  logic [7:0]  obs_rd [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] base_of(input int k);
    return (k == 0) ? 8'h21 : 8'hFE;
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic       exp_oe;
    logic [7:0] exp_out;
    for (int k = 0; k < 2; k++) begin
      exp_oe  = 1'b0;
      exp_out = 8'h00;
      if (m_active[k]) begin
        if (fsm_capture[k] && !fsm_dir_phase[k]) begin
          exp_oe  = 1'b1;
          exp_out = base_of(k) + m_idx[k];
        end else if (fsm_dir_phase[k] && m_mode[k]) begin
          exp_oe  = 1'b1;
          exp_out = ~m_idx[k];
        end
        chk("wr_idx", wr_idx[k], m_idx[k]);
      end
      chk("bus_oe", bus_oe[k], exp_oe);
      chk("bus_out", bus_out[k], exp_out);
      if (rd_valid[k]) begin
        n_rdv[k]++;
        obs_rd[rd_idx[k]] = rd_data[k];
        chk("rd_valid_expected", exp_rd.size() != 0, 1'b1);
        if (exp_rd.size() != 0) chk("rd_idx_data", {rd_idx[k], rd_data[k]}, exp_rd.pop_front());
      end
      if (done[k]) n_done[k]++;
      if (err[k]) n_err[k]++;
    end
  end

  // One single-register transaction as the bus FSM would sequence it.
  task automatic do_txn(input int k, input logic [7:0] idx, input logic mode,
                        input bit abort, input bit poke);
    int n;
    n = 0;
    @(negedge clk);
    while (!fsm_start[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fsm_start", fsm_start[k], 1'b1);
    chk("fsm_write", fsm_write[k], mode);
    m_idx[k] = idx;
    @(posedge clk); #2;
    m_active[k] = 1'b1;
    fsm_capture[k] = 1'b1; fsm_dir_phase[k] = 1'b0; fsm_rd_n[k] = 1'b1;
    if (poke) begin
      cmd_valid[k] = 1'b1; cmd_write[k] = ~mode;
    end
    @(negedge clk);
    obs_addr[idx] = bus_out[k];
    @(posedge clk); #2;
    cmd_valid[k] = 1'b0; cmd_write[k] = 1'b0;
    fsm_dir_phase[k] = 1'b1;
    @(negedge clk);
    obs_wd[idx] = bus_out[k];
    if (abort) begin
      chk("pre_reset_bus_oe", bus_oe[k], 1'b1);
      #1;
      m_active[k] = 1'b0;
      reset = 1'b1;
      #1;
      chk("async_reset_bus_oe", bus_oe[k], 1'b0);
      chk("async_reset_fsm_rst", fsm_rst[k], 1'b1);
      chk("async_reset_ready", cmd_ready[k], 1'b1);
      fsm_capture[k] = 1'b0; fsm_dir_phase[k] = 1'b0;
      return;
    end
    @(posedge clk); #2;
    fsm_capture[k] = 1'b0; fsm_rd_n[k] = 1'b0; bus_in[k] = 8'hAA;
    @(posedge clk); #2;
    bus_in[k] = 8'h10 + idx;
    @(posedge clk); #2;
    fsm_rd_n[k] = 1'b1; fsm_dir_phase[k] = 1'b0; fsm_done[k] = 1'b1; bus_in[k] = 8'h55;
    m_active[k] = 1'b0;
    if (!mode) exp_rd.push_back({idx, 8'(8'h10 + idx)});
    @(posedge clk); #2;
    fsm_done[k] = 1'b0;
    @(negedge clk);
    chk("next_fsm_rst", fsm_rst[k], 1'b1);
  endtask

  task automatic run_burst(input int k, input logic mode, input int nreg,
                           input int abort_at, input bit poke);
    int done_before;
    done_before = n_done[k];
    for (int i = 0; i < 256; i++) begin
      obs_addr[i] = 8'h5A;
      obs_wd[i]   = 8'h5A;
    end
    @(posedge clk); #2;
    cmd_valid[k] = 1'b1; cmd_write[k] = mode;
    @(posedge clk); #2;
    cmd_valid[k] = 1'b0; cmd_write[k] = 1'b0;
    chk("accepted_ready_low", cmd_ready[k], 1'b0);
    m_mode[k] = mode;
    for (int i = 0; i < nreg; i++) begin
      do_txn(k, 8'(i), mode, i == abort_at, poke && i == 1);
      if (i == abort_at) break;
    end
    if (abort_at >= 0) begin
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      @(negedge clk);
      chk("after_abort_ready", cmd_ready[k], 1'b1);
      chk("after_abort_fsm_rst", fsm_rst[k], 1'b0);
      chk("abort_no_done", n_done[k], done_before);
    end else begin
      @(negedge clk);
      chk("finish_done", done[k], 1'b1);
      chk("finish_ready", cmd_ready[k], 1'b0);
      @(negedge clk);
      chk("idle_done_low", done[k], 1'b0);
      chk("idle_ready", cmd_ready[k], 1'b1);
      chk("idle_fsm_write", fsm_write[k], 1'b0);
      chk("reads_outstanding", exp_rd.size(), 0);
      chk("done_count", n_done[k], done_before + 1);
    end
  endtask

  task automatic timeout_test(input int k);
    int n;
    int done_before;
    int err_before;
    done_before = n_done[k];
    err_before  = n_err[k];
    @(posedge clk); #2;
    cmd_valid[k] = 1'b1; cmd_write[k] = 1'b0;
    @(posedge clk); #2;
    cmd_valid[k] = 1'b0;
    @(negedge clk);
    chk("tmo_launch", fsm_start[k], 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err[k] && n < 100);
    // 63 WAIT_DONE cycles after the LAUNCH cycle, then ABORT.
    chk("tmo_cycles", n, 64);
    chk("tmo_fsm_rst", fsm_rst[k], 1'b1);
    chk("tmo_no_done", done[k], 1'b0);
    @(negedge clk);
    chk("tmo_ready", cmd_ready[k], 1'b1);
    chk("tmo_err_single", err[k], 1'b0);
    chk("tmo_err_count", n_err[k], err_before + 1);
    chk("tmo_done_count", n_done[k], done_before);
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cmd_valid[k] = 1'b0; cmd_write[k] = 1'b0;
      fsm_capture[k] = 1'b0; fsm_dir_phase[k] = 1'b0; fsm_rd_n[k] = 1'b1; fsm_done[k] = 1'b0;
      bus_in[k] = 8'h00;
      m_active[k] = 1'b0; m_mode[k] = 1'b0; m_idx[k] = 8'h00;
      n_done[k] = 0; n_err[k] = 0; n_rdv[k] = 0;
    end
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("reset_ready", cmd_ready[k], 1'b1);
        chk("reset_fsm_rst", fsm_rst[k], 1'b1);
        chk("reset_pulses", {done[k], err[k], rd_valid[k], fsm_start[k]}, 4'b0000);
      end
    end
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_fsm_rst", fsm_rst[0], 1'b0);

    // Capture flag while idle must not drive the bus.
    @(posedge clk); #2;
    fsm_capture[0] = 1'b1;
    @(negedge clk);
    chk("idle_no_drive", bus_oe[0], 1'b0);
    @(posedge clk); #2;
    fsm_capture[0] = 1'b0;

    run_burst(0, 1'b0, 9, -1, 1'b0);
    chk("read_count", n_rdv[0], 9);
    chk("read_data_0", obs_rd[0], 8'h10);
    chk("read_data_4", obs_rd[4], 8'h14);
    chk("read_data_8", obs_rd[8], 8'h18);

    run_burst(0, 1'b1, 9, -1, 1'b0);
    chk("write_no_reads", n_rdv[0], 9);
    chk("write_addr_0", obs_addr[0], 8'h21);
    chk("write_addr_8", obs_addr[8], 8'h29);
    chk("write_data_0", obs_wd[0], 8'hFF);
    chk("write_data_8", obs_wd[8], 8'hF7);

    timeout_test(0);

    run_burst(0, 1'b1, 9, 4, 1'b0);
    chk("aborted_addr_4", obs_addr[4], 8'h25);

    run_burst(0, 1'b0, 9, -1, 1'b0);
    chk("restart_addr_0", obs_addr[0], 8'h21);
    chk("restart_read_count", n_rdv[0], 18);
    chk("total_done_0", n_done[0], 3);

    run_burst(1, 1'b0, 3, -1, 1'b1);
    chk("wrap_addr_0", obs_addr[0], 8'hFE);
    chk("wrap_addr_1", obs_addr[1], 8'hFF);
    chk("wrap_addr_2", obs_addr[2], 8'h00);
    chk("wrap_read_count", n_rdv[1], 3);
    chk("wrap_read_data_2", obs_rd[2], 8'h12);
    repeat (8) begin
      @(negedge clk);
      chk("no_queued_burst", {fsm_start[1], cmd_ready[1]}, 2'b01);
    end
    chk("wrap_done_count", n_done[1], 1);
    chk("wrap_err_count", n_err[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
